// File: rtl/game_stage_seq.sv
// Multi-stage game sequencer: one stage per accepted beat, where each stage's
// bonus carries into the next. The game ends on the first failed stage, after the last stage, or on abort.
module game_stage_seq #(
  parameter int NUM_STAGES  = 4,
  parameter int SCORE_W     = 7,
  parameter int BONUS_W     = 2,
  parameter int BONUS_SHIFT = 2,
  parameter int MAX_SCORE   = 100,
  parameter int COUNT_SHIFT = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              stg_valid,
  output logic                              stg_ready,
  input  logic [SCORE_W-1:0]                work,
  input  logic [SCORE_W-1:0]                hard,
  input  logic [BONUS_W-1:0]                luck,
  output logic                              busy,
  output logic                              done,
  output logic                              game_pass,
  output logic [$clog2(NUM_STAGES+1)-1:0]   fail_stage,
  output logic [BONUS_W-1:0]                bonus_out,
  output logic [SCORE_W-1:0]                score_out
);
  localparam int IW = $clog2(NUM_STAGES+1);
  localparam int TW = SCORE_W + 2;
  localparam logic [TW-1:0]      MAX_T  = TW'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] BMAX_S = SCORE_W'((1 << BONUS_W) - 1);
  localparam logic [IW-1:0]      LAST   = IW'(NUM_STAGES - 1);
  localparam logic [IW-1:0]      NS_IDX = IW'(NUM_STAGES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [BONUS_W-1:0]  bonus_c;

  logic [TW-1:0]       total;
  logic [SCORE_W-1:0]  score, shr;
  logic [BONUS_W-1:0]  next_bonus;
  logic                pass_s;

  // Stage evaluation; TW bits hold the worst-case sum without overflow
  always_comb begin
    total      = TW'(work) + (TW'(bonus_c) << BONUS_SHIFT) + (TW'(luck) << BONUS_SHIFT);
    score      = (total > MAX_T) ? MAX_T[SCORE_W-1:0] : total[SCORE_W-1:0];
    pass_s     = (score > hard);
    shr        = score >> COUNT_SHIFT;
    next_bonus = (shr > BMAX_S) ? BMAX_S[BONUS_W-1:0] : shr[BONUS_W-1:0];
  end

  assign busy      = (state == RUN);
  assign stg_ready = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      bonus_c    <= '0;
      done       <= 1'b0;
      game_pass  <= 1'b0;
      fail_stage <= '0;
      bonus_out  <= '0;
      score_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          idx        <= '0;
          bonus_c    <= '0;
          game_pass  <= 1'b0;
          fail_stage <= '0;
          bonus_out  <= '0;
          score_out  <= '0;
        end
        RUN: begin
          // abort takes priority over a beat offered in the same cycle
          if (abort) begin
            state      <= DONE;
            done       <= 1'b1;
            game_pass  <= 1'b0;
            fail_stage <= NS_IDX;
          end else if (stg_valid) begin
            score_out <= score;
            if (!pass_s) begin
              bonus_out  <= '0;
              game_pass  <= 1'b0;
              fail_stage <= idx;
              state      <= DONE;
              done       <= 1'b1;
            end else begin
              bonus_out <= next_bonus;
              bonus_c   <= next_bonus;
              if (idx == LAST) begin
                game_pass  <= 1'b1;
                fail_stage <= NS_IDX;
                state      <= DONE;
                done       <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_stage_seq.sv
// Directed and randomized checks of game_stage_seq against a per-game model
// that works from the scoring rules in plain integer arithmetic.
module tb_game_stage_seq;
  localparam int NS = 4, SW = 7, BW = 2, BS = 2, MX = 100, CS = 5;
  localparam int IW = $clog2(NS+1);

  logic clk = 0, rst_n = 0, start = 0, abort = 0, stg_valid = 0;
  logic [SW-1:0] work = 0, hard = 0;
  logic [BW-1:0] luck = 0;
  logic stg_ready, busy, done, game_pass;
  logic [IW-1:0] fail_stage;
  logic [BW-1:0] bonus_out;
  logic [SW-1:0] score_out;

  int total = 0, bad = 0;

  // reference model state
  bit m_run = 0;
  int m_idx = 0, m_bonus = 0;
  int e_busy = 0, e_done = 0, e_pass = 0, e_fail = 0, e_bout = 0, e_score = 0;

  game_stage_seq #(.NUM_STAGES(NS), .SCORE_W(SW), .BONUS_W(BW), .BONUS_SHIFT(BS),
                   .MAX_SCORE(MX), .COUNT_SHIFT(CS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stg_valid(stg_valid),
    .stg_ready(stg_ready), .work(work), .hard(hard), .luck(luck), .busy(busy),
    .done(done), .game_pass(game_pass), .fail_stage(fail_stage),
    .bonus_out(bonus_out), .score_out(score_out));

  always #5 clk = ~clk;

  function automatic int f_score(int w, int b, int l);
    int t = w + b * (2**BS) + l * (2**BS);
    return (t > MX) ? MX : t;
  endfunction

  function automatic int f_bonus(int s);
    int b = s / (2**CS);
    return (b > 2**BW - 1) ? 2**BW - 1 : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".busy"},  32'(busy),       32'(e_busy));
    chk({tag, ".ready"}, 32'(stg_ready),  32'(e_busy));
    chk({tag, ".done"},  32'(done),       32'(e_done));
    chk({tag, ".pass"},  32'(game_pass),  32'(e_pass));
    chk({tag, ".fail"},  32'(fail_stage), 32'(e_fail));
    chk({tag, ".bonus"}, 32'(bonus_out),  32'(e_bout));
    chk({tag, ".score"}, 32'(score_out),  32'(e_score));
  endtask

  // One clock with the given inputs; the model advances and all outputs are checked.
  task automatic cyc(input string tag, input bit st, input bit ab, input bit v,
                     input int w, input int h, input int l);
    bit was_done;
    start = st; abort = ab; stg_valid = v;
    work = SW'(w); hard = SW'(h); luck = BW'(l);
    @(posedge clk); #1;
    was_done = (e_done != 0);
    e_done = 0;
    if (m_run) begin
      if (ab) begin
        e_pass = 0; e_fail = NS; e_done = 1; m_run = 0;
      end else if (v) begin
        int s = f_score(w, m_bonus, l);
        e_score = s;
        if (s > h) begin
          m_bonus = f_bonus(s); e_bout = m_bonus;
          if (m_idx == NS - 1) begin
            e_pass = 1; e_fail = NS; e_done = 1; m_run = 0;
          end else m_idx++;
        end else begin
          e_bout = 0; e_pass = 0; e_fail = m_idx; e_done = 1; m_run = 0;
        end
      end
    end else if (!was_done && st) begin
      m_run = 1; m_idx = 0; m_bonus = 0;
      e_pass = 0; e_fail = 0; e_bout = 0; e_score = 0;
    end
    e_busy = m_run ? 1 : 0;
    start = 0; abort = 0; stg_valid = 0;
    check_outs(tag);
  endtask

  task automatic reset_model();
    m_run = 0; m_idx = 0; m_bonus = 0;
    e_busy = 0; e_done = 0; e_pass = 0; e_fail = 0; e_bout = 0; e_score = 0;
  endtask

  initial begin
    // reset, then IDLE with stg_valid held high
    rst_n = 0; stg_valid = 1;
    #3 reset_model();
    check_outs("reset");
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 3; i++) cyc("idle_valid", 0, 0, 1, 90, 10, 3);

    // full pass with clamping and bonus carry
    cyc("g1_start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc("g1_beat", 0, 0, 1, 90, 50, 1);
      chk("g1_score_lit", 32'(score_out), (i == 0) ? 94 : 100);
      chk("g1_bonus_lit", 32'(bonus_out), (i == 0) ? 2 : 3);
    end
    chk("g1_done_lit", 32'(done), 1);
    chk("g1_fail_lit", 32'(fail_stage), 4);
    cyc("g1_after", 0, 0, 0, 0, 0, 0);

    // fail on the equality boundary at stage 1
    cyc("g2_start", 1, 0, 0, 0, 0, 0);
    cyc("g2_b0", 0, 0, 1, 60, 40, 0);
    chk("g2_b0_bonus_lit", 32'(bonus_out), 1);
    cyc("g2_b1", 0, 0, 1, 30, 34, 0);
    chk("g2_b1_score_lit", 32'(score_out), 34);
    chk("g2_fail_lit", 32'(fail_stage), 1);
    cyc("g2_after", 0, 0, 0, 0, 0, 0);

    // abort together with a valid beat
    cyc("g3_start", 1, 0, 0, 0, 0, 0);
    cyc("g3_b0", 0, 0, 1, 70, 10, 2);
    cyc("g3_abort", 0, 1, 1, 20, 10, 0);
    chk("g3_score_lit", 32'(score_out), 78);
    cyc("g3_after", 0, 0, 0, 0, 0, 0);

    // asynchronous reset mid-game, then a fresh game starts with bonus 0
    cyc("g4_start", 1, 0, 0, 0, 0, 0);
    cyc("g4_b0", 0, 0, 1, 100, 10, 3);
    cyc("g4_b1", 0, 0, 1, 100, 10, 3);
    rst_n = 0;
    #1 reset_model();
    check_outs("g4_async_rst");
    @(negedge clk) rst_n = 1;
    cyc("g4_restart", 1, 0, 0, 0, 0, 0);
    cyc("g4_fresh", 0, 0, 1, 50, 10, 0);
    chk("g4_fresh_score_lit", 32'(score_out), 50);
    cyc("g4_abort", 0, 1, 0, 0, 0, 0);
    cyc("g4_after", 0, 0, 0, 0, 0, 0);

    // start during RUN and during the DONE cycle is ignored
    cyc("g5_start", 1, 0, 0, 0, 0, 0);
    cyc("g5_b0", 0, 0, 1, 40, 20, 0);
    cyc("g5_start_run", 1, 0, 0, 0, 0, 0);
    cyc("g5_b1", 0, 0, 1, 10, 30, 0);
    cyc("g5_start_done", 1, 0, 0, 0, 0, 0);
    chk("g5_idle_busy_lit", 32'(busy), 0);

    // randomized games with gaps and occasional abort
    for (int g = 0; g < 40; g++) begin
      cyc("rnd_start", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && m_run; i++) begin
        bit ab = ($urandom_range(0, 19) == 0) || (i == 19);
        bit v  = ($urandom_range(0, 9) < 7);
        cyc("rnd_beat", 0, ab, v, $urandom_range(0, 127), $urandom_range(0, 110),
            $urandom_range(0, 3));
      end
      cyc("rnd_after", $urandom_range(0, 1), 0, 0, 0, 0, 0);
      if (m_run) cyc("rnd_abort", 0, 1, 0, 0, 0, 0);
      if (e_done != 0) cyc("rnd_idle", 0, 0, 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
